// File: rtl/seg_capture.sv
// Seven-segment display reader: debounces a multiplexed active-low segment bus,
// decodes each stable digit back to a hex nibble and assembles complete frames.
module seg_capture #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 65536
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [6:0]                seg_in,
    input  logic [NUM_DIGITS-1:0]     dig_sel,
    output logic [4*NUM_DIGITS-1:0]   value,
    output logic [NUM_DIGITS-1:0]     blank_mask,
    output logic                      frame_valid,
    output logic                      seg_err,
    output logic [7:0]                err_count,
    output logic                      stale
);

    localparam int unsigned SW = 7 + NUM_DIGITS;
    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Returns {legal, blank, nibble} for an active-low a..g pattern.
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {2'b10, 4'h0};
            7'h79:   decode = {2'b10, 4'h1};
            7'h24:   decode = {2'b10, 4'h2};
            7'h30:   decode = {2'b10, 4'h3};
            7'h19:   decode = {2'b10, 4'h4};
            7'h12:   decode = {2'b10, 4'h5};
            7'h02:   decode = {2'b10, 4'h6};
            7'h78:   decode = {2'b10, 4'h7};
            7'h00:   decode = {2'b10, 4'h8};
            7'h10:   decode = {2'b10, 4'h9};
            7'h08:   decode = {2'b10, 4'hA};
            7'h03:   decode = {2'b10, 4'hB};
            7'h46:   decode = {2'b10, 4'hC};
            7'h21:   decode = {2'b10, 4'hD};
            7'h06:   decode = {2'b10, 4'hE};
            7'h0E:   decode = {2'b10, 4'hF};
            7'h7F:   decode = {2'b11, 4'h0};
            default: decode = 6'b00_0000;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] x);
        is_onehot = (x != '0) && ((x & (x - NUM_DIGITS'(1))) == '0);
    endfunction

    // Reset release synchroniser; nothing samples until run goes high.
    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    logic [SW-1:0]         s_q;
    logic [CW-1:0]         stab_cnt;
    logic                  sel_ok;
    logic                  same;
    logic                  cap_fire;
    logic                  cap_q;
    logic [NUM_DIGITS-1:0] cap_sel;
    logic [6:0]            cap_seg;

    always_comb begin
        sel_ok   = is_onehot(dig_sel);
        same     = ({dig_sel, seg_in} == s_q);
        cap_fire = run && sel_ok && same && (stab_cnt == CW'(STABLE_CYCLES - 2));
    end

    // Stability filter and one-cycle capture pipeline stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_q      <= '0;
            stab_cnt <= '0;
            cap_q    <= 1'b0;
            cap_sel  <= '0;
            cap_seg  <= '0;
        end else if (run) begin
            s_q <= {dig_sel, seg_in};
            if (!sel_ok || !same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != CW'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + CW'(1);
            end
            cap_q <= cap_fire;
            if (cap_fire) begin
                cap_sel <= dig_sel;
                cap_seg <= seg_in;
            end
        end
    end

    logic [5:0]            dec;
    logic                  dec_legal;
    logic                  dec_blank;
    logic [3:0]            dec_nib;
    state_t                state;
    logic [NUM_DIGITS-1:0] captured;
    logic [NUM_DIGITS-1:0] cap_upd;
    logic [VW-1:0]         shadow_val;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [TW-1:0]         tcnt;
    logic                  full_nxt;
    logic                  tmo_at_max;
    logic                  timeout_hit;

    always_comb begin
        dec       = decode(cap_seg);
        dec_legal = dec[5];
        dec_blank = dec[4];
        dec_nib   = dec[3:0];
    end

    // Next captured mask; a commit restarts collection before applying a new capture.
    always_comb begin
        cap_upd = captured;
        if (state == COMMIT) begin
            cap_upd = '0;
        end
        if (cap_q) begin
            if (dec_legal) begin
                cap_upd = cap_upd | cap_sel;
            end else begin
                cap_upd = cap_upd & ~cap_sel;
            end
        end
        full_nxt    = &cap_upd;
        tmo_at_max  = (tcnt == TW'(FRAME_TIMEOUT - 1));
        timeout_hit = tmo_at_max && !stale && (state != COMMIT) && !full_nxt;
    end

    // Frame assembly FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            captured     <= '0;
            shadow_val   <= '0;
            shadow_blank <= '0;
            tcnt         <= '0;
            value        <= '0;
            blank_mask   <= '0;
            frame_valid  <= 1'b0;
            seg_err      <= 1'b0;
            err_count    <= 8'd0;
            stale        <= 1'b0;
        end else if (run) begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;

            if (cap_q) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    if (cap_sel[i] && dec_legal) begin
                        shadow_val[4*i +: 4] <= dec_nib;
                        shadow_blank[i]      <= dec_blank;
                    end
                end
                if (!dec_legal) begin
                    seg_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end

            if (state == COMMIT) begin
                value       <= shadow_val;
                blank_mask  <= shadow_blank;
                frame_valid <= 1'b1;
                stale       <= 1'b0;
                tcnt        <= '0;
            end else if (!tmo_at_max) begin
                tcnt <= tcnt + TW'(1);
            end

            captured <= cap_upd;
            if (timeout_hit) begin
                stale    <= 1'b1;
                captured <= '0;
                state    <= IDLE;
            end else if (full_nxt) begin
                state <= COMMIT;
            end else if (cap_upd != '0) begin
                state <= COLLECT;
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scans hand-built digit sequences and checks
// decoded frames, error pulses, saturation, timeout and mid-frame reset.
module tb_seg_capture;

    logic        clk;
    logic        resetn;
    logic [6:0]  seg_in;
    logic [3:0]  dig_sel;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        seg_err;
    logic [7:0]  err_count;
    logic        stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int se_cnt = 0;

    seg_capture #(
        .NUM_DIGITS   (4),
        .STABLE_CYCLES(4),
        .FRAME_TIMEOUT(64)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .value      (value),
        .blank_mask (blank_mask),
        .frame_valid(frame_valid),
        .seg_err    (seg_err),
        .err_count  (err_count),
        .stale      (stale)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (seg_err === 1'b1) se_cnt++;
    end

    task automatic show(input logic [3:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_in  = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        dig_sel = 4'h0;
        seg_in  = 7'h7F;
        repeat (2) @(negedge clk);
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL rst_value got=%h exp=0000", value); end
        checks++; if ({blank_mask, frame_valid, seg_err, err_count, stale} !== 15'h0) begin errors++;
            $display("FAIL rst_flags got=%h exp=0", {blank_mask, frame_valid, seg_err, err_count, stale}); end
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL rst_no_frame got=%0d exp=0", fv_cnt); end
        checks++; if ({value, stale, err_count} !== 25'h0) begin errors++;
            $display("FAIL rst_after_release got=%h exp=0", {value, stale, err_count}); end
    endtask

    task automatic test_scan();
        int base;
        base = fv_cnt;
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h24, 4);
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h19, 4);
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL scan_fv_early got=%b exp=0", frame_valid); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL scan_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL scan_value got=%h exp=1234", value); end
        checks++; if (blank_mask !== 4'b0000) begin errors++; $display("FAIL scan_blank got=%b exp=0000", blank_mask); end
        @(negedge clk);
        #1;
        checks++; if (fv_cnt - base !== 1) begin errors++; $display("FAIL scan_one_pulse got=%0d exp=1", fv_cnt - base); end
    endtask

    task automatic test_glitch();
        int base_fv;
        int base_se;
        base_fv = fv_cnt;
        base_se = se_cnt;
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h7E, 2);
        show(4'b0100, 7'h24, 4);
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h19, 4);
        repeat (2) @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL glitch_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL glitch_value got=%h exp=1234", value); end
        #1;
        checks++; if (se_cnt - base_se !== 0) begin errors++; $display("FAIL glitch_no_err got=%0d exp=0", se_cnt - base_se); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL glitch_err_count got=%0d exp=0", err_count); end
        checks++; if (fv_cnt - base_fv !== 1) begin errors++; $display("FAIL glitch_frames got=%0d exp=1", fv_cnt - base_fv); end
    endtask

    task automatic test_illegal();
        int base_se;
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h24, 4);
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h7E, 4);
        @(negedge clk);
        checks++; if (seg_err !== 1'b1) begin errors++; $display("FAIL illegal_seg_err got=%b exp=1", seg_err); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL illegal_count got=%0d exp=1", err_count); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_frame got=%b exp=0", frame_valid); end
        show(4'b0001, 7'h19, 4);
        repeat (2) @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL illegal_reshow_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL illegal_reshow_value got=%h exp=1234", value); end
        #1;
        base_se = se_cnt;
        for (int k = 0; k < 255; k++) begin
            show(4'b0000, 7'h7F, 1);
            show(4'b0001, 7'h7E, 4);
        end
        show(4'b0000, 7'h7F, 1);
        #1;
        checks++; if (se_cnt - base_se !== 255) begin errors++; $display("FAIL sat_pulses got=%0d exp=255", se_cnt - base_se); end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", err_count); end
    endtask

    task automatic test_multihot_blank();
        int base_se;
        base_se = se_cnt;
        show(4'b0011, 7'h7E, 10);
        show(4'b0000, 7'h7F, 2);
        #1;
        checks++; if (se_cnt - base_se !== 0) begin errors++; $display("FAIL multihot_no_err got=%0d exp=0", se_cnt - base_se); end
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL multihot_stale got=%b exp=1", stale); end
        show(4'b1000, 7'h7F, 4);
        show(4'b0100, 7'h24, 4);
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h19, 4);
        repeat (2) @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL blank_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h0234) begin errors++; $display("FAIL blank_value got=%h exp=0234", value); end
        checks++; if (blank_mask !== 4'b1000) begin errors++; $display("FAIL blank_mask got=%b exp=1000", blank_mask); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL blank_stale_clr got=%b exp=0", stale); end
    endtask

    task automatic test_timeout();
        int base_fv;
        show(4'b1000, 7'h08, 4);
        show(4'b0100, 7'h03, 4);
        show(4'b0010, 7'h46, 4);
        show(4'b0001, 7'h21, 4);
        repeat (2) @(negedge clk);
        checks++; if (value !== 16'hABCD) begin errors++; $display("FAIL abcd_value got=%h exp=abcd", value); end
        #1;
        base_fv = fv_cnt;
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h24, 4);
        show(4'b0000, 7'h7F, 55);
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL tmo_before got=%b exp=0", stale); end
        @(negedge clk);
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL tmo_stale got=%b exp=1", stale); end
        checks++; if (value !== 16'hABCD) begin errors++; $display("FAIL tmo_value_kept got=%h exp=abcd", value); end
        #1;
        checks++; if (fv_cnt - base_fv !== 0) begin errors++; $display("FAIL tmo_no_frame got=%0d exp=0", fv_cnt - base_fv); end
        show(4'b1000, 7'h12, 4);
        show(4'b0100, 7'h02, 4);
        show(4'b0010, 7'h78, 4);
        show(4'b0001, 7'h00, 4);
        repeat (2) @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL resume_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h5678) begin errors++; $display("FAIL resume_value got=%h exp=5678", value); end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL resume_stale got=%b exp=0", stale); end
    endtask

    task automatic test_back_to_back();
        show(4'b1000, 7'h10, 4);
        show(4'b0100, 7'h06, 4);
        show(4'b0010, 7'h0E, 4);
        show(4'b0001, 7'h40, 4);
        repeat (2) @(negedge clk);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv got=%b exp=1", frame_valid); end
        checks++; if (value !== 16'h9EF0) begin errors++; $display("FAIL b2b_value got=%h exp=9ef0", value); end
    endtask

    task automatic test_reset_mid_frame();
        int base_fv;
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h24, 2);
        resetn = 1'b0;
        #1;
        checks++; if (value !== 16'h0) begin errors++; $display("FAIL midrst_value got=%h exp=0000", value); end
        checks++; if ({blank_mask, err_count, stale} !== 13'h0) begin errors++;
            $display("FAIL midrst_flags got=%h exp=0", {blank_mask, err_count, stale}); end
        @(negedge clk);
        resetn = 1'b1;
        base_fv = fv_cnt;
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h19, 4);
        show(4'b0000, 7'h7F, 4);
        #1;
        checks++; if (fv_cnt - base_fv !== 0) begin errors++; $display("FAIL midrst_discard got=%0d exp=0", fv_cnt - base_fv); end
        show(4'b1000, 7'h79, 4);
        show(4'b0100, 7'h24, 4);
        show(4'b0010, 7'h30, 4);
        show(4'b0001, 7'h19, 4);
        repeat (2) @(negedge clk);
        checks++; if (value !== 16'h1234) begin errors++; $display("FAIL midrst_refill got=%h exp=1234", value); end
    endtask

    initial begin
        resetn  = 1'b0;
        dig_sel = 4'h0;
        seg_in  = 7'h7F;
        test_reset();
        test_scan();
        test_glitch();
        test_illegal();
        test_multihot_blank();
        test_timeout();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
